bus_fabric: RTL and testbench

- Parametrised successor to the fixed DB/SB/ADH/ADL bus combiner of the MOS_6502 CPU.
- Any number of WIDTH-bit wired-AND internal buses, with open-drain force-low masks (O_ADLx/O_ADHx style) per bus.
- Configurable pass-gate links between bus pairs; chained links are resolved transitively.
- Adds the dynamic-bus behaviour the CPU needs and the old combinational block lacks: precharge, charge retention on undriven buses, and leakage decay after a configurable number of cycles.

---
 rtl/bus_fabric_pkg.sv | 24 ++
 rtl/bus_hold_cell.sv | 50 +++++
 rtl/bus_fabric.sv | 138 +++++++++++++
 tb/tb_bus_fabric.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared types and helpers for the bus fabric.
// Bus index width, CPU bus numbering and link-map decoding.
package bus_fabric_pkg;

    localparam int BUS_IDX_W = 4;
    localparam int MAX_BUSES = 16;
    localparam int MAX_LINKS = 64;
    localparam int LINK_MAP_W = BUS_IDX_W * MAX_LINKS;

    typedef logic [BUS_IDX_W-1:0] bus_idx_t;

    localparam bus_idx_t BUS_DB  = 4'd0;
    localparam bus_idx_t BUS_SB  = 4'd1;
    localparam bus_idx_t BUS_ADH = 4'd2;
    localparam bus_idx_t BUS_ADL = 4'd3;

    function automatic bus_idx_t link_idx(
        input logic [LINK_MAP_W-1:0] map,
        input int k
    );
        return map[k*BUS_IDX_W +: BUS_IDX_W];
    endfunction

endpackage

// File: rtl/bus_hold_cell.sv
// Per-bus dynamic charge: retention, precharge and leakage decay.
// Priority: reset, driven, precharge, decay, charge sharing.
module bus_hold_cell
    import bus_fabric_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DECAY_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grp_driven,
    input  logic             precharge,
    input  logic [WIDTH-1:0] resolved,
    output logic [WIDTH-1:0] hold_q,
    output logic             decayed_q
);

    localparam int CNT_W =
        (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] decay_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '1;
            decay_cnt <= '0;
            decayed_q <= 1'b0;
        end else if (grp_driven) begin
            hold_q    <= resolved;
            decay_cnt <= '0;
            decayed_q <= 1'b0;
        end else if (precharge) begin
            hold_q    <= '1;
            decay_cnt <= '0;
            decayed_q <= 1'b0;
        end else if (DECAY_CYCLES != 0 && decay_cnt == CNT_LAST) begin
            // leaked charge reads as all-ones; counter parks here
            hold_q    <= '1;
            decayed_q <= 1'b1;
        end else begin
            hold_q <= resolved;
            if (decay_cnt != CNT_MAX) begin
                decay_cnt <= decay_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Wired-AND dynamic bus fabric with transitive pass-gate links.
// Optional driver-fight detection: BUS_FABRIC_CONFLICT_DETECT_EN.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int NUM_BUSES    = 3,
    parameter int WIDTH        = 8,
    parameter int NUM_LINKS    = 2,
    parameter logic [BUS_IDX_W*NUM_LINKS-1:0] LINK_A_MAP = {4'd1, 4'd1},
    parameter logic [BUS_IDX_W*NUM_LINKS-1:0] LINK_B_MAP = {4'd2, 4'd0},
    parameter int DECAY_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BUSES-1:0]       bus_drv_en,
    input  logic [NUM_BUSES*WIDTH-1:0] bus_from_modules,
    input  logic [NUM_BUSES*WIDTH-1:0] bus_mask,
    input  logic [NUM_LINKS-1:0]       link_en,
    input  logic                       precharge,
    output logic [NUM_BUSES*WIDTH-1:0] bus_to_modules,
    output logic [NUM_BUSES-1:0]       bus_undriven,
    output logic [NUM_BUSES-1:0]       bus_decayed,
    output logic [NUM_BUSES-1:0]       bus_conflict
);

    localparam logic [LINK_MAP_W-1:0] A_MAP = LINK_MAP_W'(LINK_A_MAP);
    localparam logic [LINK_MAP_W-1:0] B_MAP = LINK_MAP_W'(LINK_B_MAP);

    logic [NUM_BUSES-1:0] grp [NUM_BUSES];
    logic [NUM_BUSES-1:0] bus_drv;
    logic [NUM_BUSES-1:0] grp_driven;
    logic [WIDTH-1:0]     contrib  [NUM_BUSES];
    logic [WIDTH-1:0]     hold_q   [NUM_BUSES];
    logic [WIDTH-1:0]     resolved [NUM_BUSES];

    // each pass extends every group by at least one link hop
    always_comb begin
        int a;
        int b;
        a = 0;
        b = 0;
        for (int i = 0; i < NUM_BUSES; i++) begin
            grp[i]    = '0;
            grp[i][i] = 1'b1;
        end
        for (int p = 0; p < NUM_BUSES - 1; p++) begin
            for (int k = 0; k < NUM_LINKS; k++) begin
                a = int'(link_idx(A_MAP, k));
                b = int'(link_idx(B_MAP, k));
                if (link_en[k] && a < NUM_BUSES && b < NUM_BUSES) begin
                    grp[a] = grp[a] | grp[b];
                    grp[b] = grp[a];
                end
            end
        end
    end

    always_comb begin
        logic [WIDTH-1:0] c_acc;
        logic [WIDTH-1:0] h_acc;
        c_acc = '1;
        h_acc = '1;
        for (int i = 0; i < NUM_BUSES; i++) begin
            bus_drv[i] = bus_drv_en[i]
                       | ~&bus_mask[i*WIDTH +: WIDTH];
            contrib[i] = (bus_drv_en[i] ? bus_from_modules[i*WIDTH +: WIDTH]
                                        : {WIDTH{1'b1}})
                       & bus_mask[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < NUM_BUSES; i++) begin
            c_acc = '1;
            h_acc = '1;
            for (int j = 0; j < NUM_BUSES; j++) begin
                if (grp[i][j]) begin
                    c_acc = c_acc & contrib[j];
                    h_acc = h_acc & hold_q[j];
                end
            end
            grp_driven[i] = |(grp[i] & bus_drv);
            resolved[i]   = grp_driven[i] ? c_acc : h_acc;
        end
    end

    for (genvar i = 0; i < NUM_BUSES; i++) begin : g_bus
        assign bus_to_modules[i*WIDTH +: WIDTH] = resolved[i];
        assign bus_undriven[i] = ~grp_driven[i];

        bus_hold_cell #(
            .WIDTH        (WIDTH),
            .DECAY_CYCLES (DECAY_CYCLES)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .grp_driven (grp_driven[i]),
            .precharge  (precharge),
            .resolved   (resolved[i]),
            .hold_q     (hold_q[i]),
            .decayed_q  (bus_decayed[i])
        );
    end

`ifdef BUS_FABRIC_CONFLICT_DETECT_EN
    logic [NUM_BUSES-1:0] conflict_now;
    logic [NUM_BUSES-1:0] conflict_q;

    // masks are excluded: only module drivers can fight
    always_comb begin
        logic [WIDTH-1:0] zeros;
        logic [WIDTH-1:0] ones;
        zeros = '0;
        ones  = '0;
        for (int i = 0; i < NUM_BUSES; i++) begin
            zeros = '0;
            ones  = '0;
            for (int j = 0; j < NUM_BUSES; j++) begin
                if (grp[i][j] && bus_drv_en[j]) begin
                    zeros = zeros | ~bus_from_modules[j*WIDTH +: WIDTH];
                    ones  = ones  |  bus_from_modules[j*WIDTH +: WIDTH];
                end
            end
            conflict_now[i] = |(zeros & ones);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_q | conflict_now;
        end
    end

    assign bus_conflict = conflict_q;
`else
    assign bus_conflict = '0;
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: group/label model plus directed literals.
// Conflict expectations follow BUS_FABRIC_CONFLICT_DETECT_EN.
module tb_bus_fabric;

    localparam int NB    = 3;
    localparam int W     = 8;
    localparam int NL    = 2;
    localparam int DECAY = 16;
`ifdef BUS_FABRIC_CONFLICT_DETECT_EN
    localparam bit HAS_CONF = 1'b1;
`else
    localparam bit HAS_CONF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NB-1:0]   bus_drv_en;
    logic [NB*W-1:0] bus_from_modules;
    logic [NB*W-1:0] bus_mask;
    logic [NL-1:0]   link_en;
    logic            precharge;
    logic [NB*W-1:0] bus_to_modules;
    logic [NB-1:0]   bus_undriven;
    logic [NB-1:0]   bus_decayed;
    logic [NB-1:0]   bus_conflict;

    always #5 clk = ~clk;

    bus_fabric #(
        .NUM_BUSES    (NB),
        .WIDTH        (W),
        .NUM_LINKS    (NL),
        .LINK_A_MAP   ({4'd1, 4'd1}),
        .LINK_B_MAP   ({4'd2, 4'd0}),
        .DECAY_CYCLES (DECAY)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_drv_en       (bus_drv_en),
        .bus_from_modules (bus_from_modules),
        .bus_mask         (bus_mask),
        .link_en          (link_en),
        .precharge        (precharge),
        .bus_to_modules   (bus_to_modules),
        .bus_undriven     (bus_undriven),
        .bus_decayed      (bus_decayed),
        .bus_conflict     (bus_conflict)
    );

    int checks = 0;
    int errors = 0;

    int la [NL] = '{1, 1};
    int lb [NL] = '{0, 2};

    logic [W-1:0] m_hold [NB];
    int           m_idle [NB];
    bit           m_dec  [NB];
    bit           m_conf [NB];
    logic [W-1:0] m_out  [NB];
    bit           m_gdrv [NB];
    bit           m_cnow [NB];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // groups by min-label flooding until stable
    task automatic model_eval();
        int lab [NB];
        bit chg;
        logic [W-1:0] f, c, hc, z, o;
        bit gd;
        for (int i = 0; i < NB; i++) lab[i] = i;
        do begin
            chg = 1'b0;
            for (int k = 0; k < NL; k++) begin
                if (link_en[k] && lab[la[k]] != lab[lb[k]]) begin
                    int mn;
                    mn = (lab[la[k]] < lab[lb[k]]) ? lab[la[k]] : lab[lb[k]];
                    lab[la[k]] = mn;
                    lab[lb[k]] = mn;
                    chg = 1'b1;
                end
            end
        end while (chg);
        for (int i = 0; i < NB; i++) begin
            gd = 1'b0;
            c  = 8'hFF;
            hc = 8'hFF;
            z  = 8'h00;
            o  = 8'h00;
            for (int j = 0; j < NB; j++) begin
                if (lab[j] == lab[i]) begin
                    f = bus_from_modules[j*W +: W];
                    if (bus_drv_en[j] || bus_mask[j*W +: W] != 8'hFF) gd = 1'b1;
                    c  = c & (bus_drv_en[j] ? f : 8'hFF) & bus_mask[j*W +: W];
                    hc = hc & m_hold[j];
                    if (bus_drv_en[j]) begin
                        z = z | ~f;
                        o = o | f;
                    end
                end
            end
            m_gdrv[i] = gd;
            m_out[i]  = gd ? c : hc;
            m_cnow[i] = (z & o) != 8'h00;
        end
    endtask

    task automatic compare();
        logic [NB*W-1:0] e_bus;
        logic [NB-1:0]   e_und, e_dec, e_conf;
        #1;
        model_eval();
        for (int i = 0; i < NB; i++) begin
            e_bus[i*W +: W] = m_out[i];
            e_und[i]  = !m_gdrv[i];
            e_dec[i]  = m_dec[i];
            e_conf[i] = HAS_CONF && m_conf[i];
        end
        chk("bus_to_modules", 64'(bus_to_modules), 64'(e_bus));
        chk("bus_undriven", 64'(bus_undriven), 64'(e_und));
        chk("bus_decayed", 64'(bus_decayed), 64'(e_dec));
        chk("bus_conflict", 64'(bus_conflict), 64'(e_conf));
    endtask

    task automatic edge_step();
        @(posedge clk);
        for (int i = 0; i < NB; i++) begin
            if (rst) begin
                m_hold[i] = 8'hFF;
                m_idle[i] = 0;
                m_dec[i]  = 1'b0;
                m_conf[i] = 1'b0;
            end else begin
                m_conf[i] = m_conf[i] | (m_gdrv[i] && m_cnow[i]);
                if (m_gdrv[i] || precharge) begin
                    m_hold[i] = m_gdrv[i] ? m_out[i] : 8'hFF;
                    m_idle[i] = 0;
                    m_dec[i]  = 1'b0;
                end else begin
                    m_idle[i]++;
                    if (DECAY != 0 && m_idle[i] >= DECAY) begin
                        m_hold[i] = 8'hFF;
                        m_dec[i]  = 1'b1;
                    end else begin
                        m_hold[i] = m_out[i];
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic [2:0] d, input logic [23:0] f,
                          input logic [23:0] m, input logic [1:0] l,
                          input logic p, input logic r);
        bus_drv_en       = d;
        bus_from_modules = f;
        bus_mask         = m;
        link_en          = l;
        precharge        = p;
        rst              = r;
    endtask

    task automatic cycle();
        compare();
        edge_step();
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h0F;
            3:       return 8'hF0;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [23:0] f, m;
        logic [2:0]  d;
        bit quiet;
        for (int i = 0; i < NB; i++) begin
            m_hold[i] = 8'hFF;
            m_idle[i] = 0;
            m_dec[i]  = 1'b0;
            m_conf[i] = 1'b0;
        end
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        cycle();
        cycle();

        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        compare();
        chk("reset_bus", 64'(bus_to_modules), 64'hFFFFFF);
        chk("reset_undriven", 64'(bus_undriven), 64'h7);
        chk("reset_decayed", 64'(bus_decayed), 64'h0);
        edge_step();

        set_in(3'b011, 24'hFF3CA5, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        compare();
        chk("nolink_bus", 64'(bus_to_modules), 64'hFF3CA5);
        chk("nolink_undriven", 64'(bus_undriven), 64'h4);
        edge_step();

        set_in(3'b111, 24'hFF3CF0, 24'hFFFFFF, 2'b11, 1'b0, 1'b0);
        compare();
        chk("chain_bus", 64'(bus_to_modules), 64'h303030);
        edge_step();

        set_in(3'b000, 24'h000000, 24'hFEFFFF, 2'b10, 1'b0, 1'b0);
        compare();
        chk("mask_sb_adh", 64'(bus_to_modules[23:8]), 64'hFEFE);
        chk("mask_undriven", 64'(bus_undriven[2:1]), 64'h0);
        edge_step();

        set_in(3'b010, 24'hFF42FF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        cycle();
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < DECAY; k++) begin
            compare();
            chk("hold_sb", 64'(bus_to_modules[15:8]), 64'h42);
            chk("hold_dec", 64'(bus_decayed[1]), 64'h0);
            edge_step();
        end
        compare();
        chk("decay_sb", 64'(bus_to_modules[15:8]), 64'hFF);
        chk("decay_flag", 64'(bus_decayed[1]), 64'h1);
        edge_step();

        set_in(3'b010, 24'hFF42FF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        cycle();
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b1, 1'b0);
        cycle();
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        compare();
        chk("precharge_sb", 64'(bus_to_modules[15:8]), 64'hFF);
        edge_step();

        set_in(3'b010, 24'hFF42FF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        cycle();
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cycle();
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, 1'b1);
        compare();
        chk("prerst_sb", 64'(bus_to_modules[15:8]), 64'h42);
        edge_step();
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
        compare();
        chk("rst_sb", 64'(bus_to_modules[15:8]), 64'hFF);
        chk("rst_dec", 64'(bus_decayed), 64'h0);
        edge_step();

        set_in(3'b011, 24'hFFF00F, 24'hFFFFFF, 2'b01, 1'b0, 1'b0);
        compare();
        chk("fight_bus", 64'(bus_to_modules[15:0]), 64'h0000);
        edge_step();
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b01, 1'b0, 1'b0);
        compare();
        chk("fight_flag", 64'(bus_conflict), HAS_CONF ? 64'h3 : 64'h0);
        edge_step();
        compare();
        chk("fight_sticky", 64'(bus_conflict), HAS_CONF ? 64'h3 : 64'h0);
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b01, 1'b0, 1'b1);
        edge_step();
        set_in(3'b000, 24'hFFFFFF, 24'hFFFFFF, 2'b01, 1'b0, 1'b0);
        compare();
        chk("fight_clear", 64'(bus_conflict), 64'h0);
        edge_step();

        for (int n = 0; n < 4000; n++) begin
            quiet = ((n / 400) % 2) == 1;
            for (int i = 0; i < NB; i++) begin
                d[i] = quiet ? ($urandom_range(0, 31) == 0)
                             : ($urandom_range(0, 1) == 0);
                f[i*W +: W] = pick();
                m[i*W +: W] = ($urandom_range(0, quiet ? 31 : 7) == 0)
                            ? 8'($urandom) : 8'hFF;
            end
            set_in(d, f, m, 2'($urandom),
                   $urandom_range(0, quiet ? 63 : 15) == 0,
                   $urandom_range(0, 299) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
